// File: rtl/bin2onehot_decoder.sv
// Binary index to one-hot decoder with valid/ready on both sides.
// A registered output stage and a one-entry skid buffer keep full throughput without a combinational ready path.
module bin2onehot_decoder #(
  parameter int WIDTH_DATA_OUT = 32,
  parameter int WIDTH_DATA_IN  = $clog2(WIDTH_DATA_OUT) + 1,
  parameter int WIDTH_ERR_CNT  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH_DATA_IN-1:0]  in_index,
  input  logic                      in_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH_DATA_OUT-1:0] out_onehot,
  output logic [WIDTH_DATA_IN-1:0]  out_index,
  output logic                      out_err,
  input  logic                      err_clr,
  output logic [WIDTH_ERR_CNT-1:0]  err_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // One extra bit so the output width itself is representable for the range compare.
  localparam logic [WIDTH_DATA_IN:0]  INDEX_LIMIT = (WIDTH_DATA_IN + 1)'(WIDTH_DATA_OUT);
  localparam logic [WIDTH_DATA_OUT-1:0] ONEHOT_LSB = {{(WIDTH_DATA_OUT-1){1'b0}}, 1'b1};

  logic [1:0]                state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic [WIDTH_DATA_OUT-1:0] out_onehot_q, out_onehot_d;
  logic [WIDTH_DATA_IN-1:0]  out_index_q, out_index_d;
  logic                      out_err_q, out_err_d;
  logic [WIDTH_DATA_OUT-1:0] skid_onehot_q, skid_onehot_d;
  logic [WIDTH_DATA_IN-1:0]  skid_index_q, skid_index_d;
  logic                      skid_err_q, skid_err_d;
  logic [WIDTH_ERR_CNT-1:0]  err_count_q, err_count_d;

  logic                      dec_in_range;
  logic                      dec_err;
  logic [WIDTH_DATA_OUT-1:0] dec_onehot;
  logic                      accept;
  logic                      consume;

  always_comb begin
    dec_in_range = ({1'b0, in_index} < INDEX_LIMIT);
    dec_err      = in_en & ~dec_in_range;
    dec_onehot   = (in_en & dec_in_range) ? (ONEHOT_LSB << in_index) : '0;
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    out_onehot_d  = out_onehot_q;
    out_index_d   = out_index_q;
    out_err_d     = out_err_q;
    skid_onehot_d = skid_onehot_q;
    skid_index_d  = skid_index_q;
    skid_err_d    = skid_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_onehot_d = dec_onehot;
          out_index_d  = in_index;
          out_err_d    = dec_err;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          out_onehot_d = dec_onehot;
          out_index_d  = in_index;
          out_err_d    = dec_err;
        end else if (accept) begin
          skid_onehot_d = dec_onehot;
          skid_index_d  = in_index;
          skid_err_d    = dec_err;
          state_d       = ST_TWO;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so the only event is draining SKID into OUT.
        if (consume) begin
          out_onehot_d = skid_onehot_q;
          out_index_d  = skid_index_q;
          out_err_d    = skid_err_q;
          state_d      = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d != ST_TWO);
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (consume && out_err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + WIDTH_ERR_CNT'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      in_ready_q    <= 1'b0;
      out_onehot_q  <= '0;
      out_index_q   <= '0;
      out_err_q     <= 1'b0;
      skid_onehot_q <= '0;
      skid_index_q  <= '0;
      skid_err_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_onehot_q  <= out_onehot_d;
      out_index_q   <= out_index_d;
      out_err_q     <= out_err_d;
      skid_onehot_q <= skid_onehot_d;
      skid_index_q  <= skid_index_d;
      skid_err_q    <= skid_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_onehot = out_onehot_q;
  assign out_index  = out_index_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_bin2onehot_decoder.sv
// Testbench for bin2onehot_decoder: table vectors, directed flow-control sequences
// and random traffic checked against a queue-based model of the stored beats.
module tb_bin2onehot_decoder;

  localparam int W_OUT = 32;
  localparam int W_IN  = 6;
  localparam int W_CNT = 8;
  localparam int CNT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W_IN-1:0]   in_index;
  logic              in_en;
  logic              out_valid;
  logic              out_ready;
  logic [W_OUT-1:0]  out_onehot;
  logic [W_IN-1:0]   out_index;
  logic              out_err;
  logic              err_clr;
  logic [W_CNT-1:0]  err_count;

  bin2onehot_decoder #(
    .WIDTH_DATA_OUT(W_OUT),
    .WIDTH_DATA_IN (W_IN),
    .WIDTH_ERR_CNT (W_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_index  (in_index),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_onehot(out_onehot),
    .out_index (out_index),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W_OUT-1:0] onehot;
    logic [W_IN-1:0]  index;
    logic             err;
  } beat_t;

  typedef struct {
    logic             en;
    logic [W_IN-1:0]  idx;
    logic [W_OUT-1:0] exp_onehot;
    logic             exp_err;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  beat_t mq[$];
  logic  m_ready;
  int    m_cnt;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t refDecode(input logic en, input logic [W_IN-1:0] idx);
    beat_t b;
    b.onehot = '0;
    b.index  = idx;
    b.err    = 1'b0;
    if (en) begin
      if (int'(idx) < W_OUT) b.onehot[idx] = 1'b1;
      else b.err = 1'b1;
    end
    return b;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_ready = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic checkState();
    checkOutput("in_ready", 64'(in_ready), 64'(m_ready));
    checkOutput("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    checkOutput("err_count", 64'(err_count), 64'(m_cnt));
    if (mq.size() > 0) begin
      checkOutput("out_onehot", 64'(out_onehot), 64'(mq[0].onehot));
      checkOutput("out_index", 64'(out_index), 64'(mq[0].index));
      checkOutput("out_err", 64'(out_err), 64'(mq[0].err));
    end
  endtask

  // Called at a negedge: check, drive, advance the model at posedge, return at the next negedge.
  task automatic applyStimulus(input logic v, input logic en, input logic [W_IN-1:0] idx,
                               input logic ordy, input logic clr,
                               input logic use_tab, input beat_t tab);
    logic  acc, con;
    beat_t b;
    checkState();
    in_valid  = v;
    in_en     = en;
    in_index  = idx;
    out_ready = ordy;
    err_clr   = clr;
    @(posedge clk);
    acc = v && m_ready;
    con = (mq.size() > 0) && ordy;
    if (clr) m_cnt = 0;
    else if (con && mq[0].err && m_cnt < CNT_MAX) m_cnt++;
    if (con) void'(mq.pop_front());
    if (acc) begin
      b = use_tab ? tab : refDecode(en, idx);
      mq.push_back(b);
    end
    m_ready = (mq.size() < 2);
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic en, input logic [W_IN-1:0] idx,
                      input logic ordy, input logic clr);
    beat_t dummy;
    dummy = '{onehot: '0, index: '0, err: 1'b0};
    applyStimulus(v, en, idx, ordy, clr, 1'b0, dummy);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_out_onehot"}, 64'(out_onehot), 64'd0);
    checkOutput({tag, "_out_index"}, 64'(out_index), 64'd0);
    checkOutput({tag, "_out_err"}, 64'(out_err), 64'd0);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    beat_t tb;
    rst = 1'b1; in_valid = 1'b0; in_en = 1'b0; in_index = '0; out_ready = 1'b0; err_clr = 1'b0;
    modelReset();

    vecs[0] = '{en: 1'b1, idx: 6'd32, exp_onehot: 32'h0000_0000, exp_err: 1'b1};
    vecs[1] = '{en: 1'b1, idx: 6'd63, exp_onehot: 32'h0000_0000, exp_err: 1'b1};
    vecs[2] = '{en: 1'b0, idx: 6'd7,  exp_onehot: 32'h0000_0000, exp_err: 1'b0};
    vecs[3] = '{en: 1'b1, idx: 6'd0,  exp_onehot: 32'h0000_0001, exp_err: 1'b0};
    vecs[4] = '{en: 1'b1, idx: 6'd31, exp_onehot: 32'h8000_0000, exp_err: 1'b0};
    vecs[5] = '{en: 1'b1, idx: 6'd5,  exp_onehot: 32'h0000_0020, exp_err: 1'b0};
    vecs[6] = '{en: 1'b0, idx: 6'd40, exp_onehot: 32'h0000_0000, exp_err: 1'b0};
    vecs[7] = '{en: 1'b1, idx: 6'd17, exp_onehot: 32'h0002_0000, exp_err: 1'b0};

    repeat (2) @(negedge clk);
    checkResetValues("init");
    rst = 1'b0;
    modelReset();

    $display("[TB] table vectors");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    foreach (vecs[i]) begin
      tb = '{onehot: vecs[i].exp_onehot, index: vecs[i].idx, err: vecs[i].exp_err};
      applyStimulus(1'b1, vecs[i].en, vecs[i].idx, 1'b1, 1'b0, 1'b1, tb);
    end
    repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("tab_err_count", 64'(err_count), 64'd2);

    $display("[TB] full-rate stream");
    for (int i = 0; i < W_OUT; i++) step(1'b1, 1'b1, W_IN'(i), 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    $display("[TB] backpressure");
    repeat (3) step(1'b1, 1'b1, 6'd5, 1'b0, 1'b0);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (3) step(1'b0, 1'b1, 6'd5, 1'b1, 1'b0);
    checkOutput("bp_drained", 64'(out_valid), 64'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), W_IN'($urandom_range(0, 63)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    end
    repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    $display("[TB] error counter saturation");
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 6'd40, 1'b1, 1'b0);
    checkOutput("sat_err_count", 64'(err_count), 64'(CNT_MAX));
    checkOutput("sat_out_err", 64'(out_err), 64'd1);
    step(1'b1, 1'b1, 6'd50, 1'b1, 1'b1);
    checkOutput("clr_err_count", 64'(err_count), 64'd0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    $display("[TB] reset mid-stream");
    step(1'b1, 1'b1, 6'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'd9, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkResetValues("async");
    @(posedge clk);
    @(negedge clk);
    checkResetValues("held");
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, W_IN'(i + 20), 1'($urandom_range(0, 1)), 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkState();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
